// File: rtl/maze_core.sv
// Maze game engine: player position, map-validated moves via a read handshake,
// countdown timer and win/lose status. Optional move counter under MAZE_MOVE_COUNT_EN.
module maze_core #(
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int POS_W     = 3,
    parameter int ADDR_W    = 6,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int TIME_W    = 8,
    parameter int TIME_INIT = 60,
    parameter int TICK_DIV  = 50_000_000
) (
    input  logic              clk,
    input  logic              nst,
    input  logic              restart,
    input  logic              move_valid,
    input  logic [1:0]        move_dir,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    input  logic              mem_rdy,
    output logic [POS_W-1:0]  pos_x,
    output logic [POS_W-1:0]  pos_y,
    output logic [TIME_W-1:0] time_left,
    output logic              busy,
    output logic              move_ok,
    output logic              move_rej,
    output logic              playing,
    output logic              won,
    output logic              lost
`ifdef MAZE_MOVE_COUNT_EN
    ,
    output logic [7:0]        move_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_WON   = 3'd4,
        S_LOST  = 3'd5
    } state_t;

    localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [POS_W:0]    GRID_W_E = (POS_W+1)'(GRID_W);
    localparam logic [POS_W:0]    GRID_H_E = (POS_W+1)'(GRID_H);
    localparam logic [POS_W:0]    ONE_E    = (POS_W+1)'(1);
    localparam logic [POS_W-1:0]  ONE_P    = POS_W'(1);
    localparam logic [POS_W-1:0]  ZERO_P   = POS_W'(0);
    localparam logic [POS_W-1:0]  START_XP = POS_W'(START_X);
    localparam logic [POS_W-1:0]  START_YP = POS_W'(START_Y);
    localparam logic [TIME_W-1:0] TIME_LD  = TIME_W'(TIME_INIT);
    localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);
    localparam logic [TIME_W-1:0] TIME_Z   = TIME_W'(0);

    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [POS_W-1:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                busy_q, busy_d;
    logic                ok_q, ok_d;
    logic                rej_q, rej_d;
    logic                playing_q, playing_d;
    logic                won_q, won_d;
    logic                lost_q, lost_d;
`ifdef MAZE_MOVE_COUNT_EN
    logic [7:0]          mcnt_q, mcnt_d;
`endif

    logic [POS_W-1:0]    step_x_s, step_y_s;
    logic                step_ok_s;
    logic [ADDR_W-1:0]   step_addr_s;
    logic                live_s, wrap_s, timeout_s;

    // Candidate target cell for the requested direction and whether it lies on the grid.
    always_comb begin
        step_x_s  = pos_x_q;
        step_y_s  = pos_y_q;
        step_ok_s = 1'b0;
        case (move_dir)
            2'd0: begin
                if (pos_y_q != ZERO_P) begin
                    step_y_s  = pos_y_q - ONE_P;
                    step_ok_s = 1'b1;
                end else begin
                    step_ok_s = 1'b0;
                end
            end
            2'd1: begin
                if (({1'b0, pos_y_q} + ONE_E) < GRID_H_E) begin
                    step_y_s  = pos_y_q + ONE_P;
                    step_ok_s = 1'b1;
                end else begin
                    step_ok_s = 1'b0;
                end
            end
            2'd2: begin
                if (pos_x_q != ZERO_P) begin
                    step_x_s  = pos_x_q - ONE_P;
                    step_ok_s = 1'b1;
                end else begin
                    step_ok_s = 1'b0;
                end
            end
            2'd3: begin
                if (({1'b0, pos_x_q} + ONE_E) < GRID_W_E) begin
                    step_x_s  = pos_x_q + ONE_P;
                    step_ok_s = 1'b1;
                end else begin
                    step_ok_s = 1'b0;
                end
            end
            default: step_ok_s = 1'b0;
        endcase
        step_addr_s = ADDR_W'(step_y_s) * ADDR_W'(GRID_W) + ADDR_W'(step_x_s);
    end

    // Timer prescaler and countdown; only advances while a game is live.
    always_comb begin
        live_s    = (state_q == S_PLAY) || (state_q == S_FETCH) || (state_q == S_WAIT);
        wrap_s    = live_s && (cnt_q == CNT_MAX);
        timeout_s = wrap_s && (time_q == TIME_ONE);
        cnt_d     = cnt_q;
        time_d    = time_q;
        if (live_s) begin
            cnt_d = wrap_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);
        end else begin
            cnt_d = cnt_q;
        end
        if (wrap_s && (time_q != TIME_Z)) begin
            time_d = time_q - TIME_ONE;
        end else begin
            time_d = time_q;
        end
        if (restart) begin
            cnt_d  = {CNT_W{1'b0}};
            time_d = TIME_LD;
        end else begin
            cnt_d  = cnt_d;
        end
    end

    // Game FSM next state, position update and registered output values.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        mem_addr_d = mem_addr_q;
        ok_d       = 1'b0;
        rej_d      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_PLAY: begin
                if (move_valid && step_ok_s) begin
                    state_d    = S_FETCH;
                    tgt_x_d    = step_x_s;
                    tgt_y_d    = step_y_s;
                    mem_addr_d = step_addr_s;
                end else if (move_valid) begin
                    rej_d = 1'b1;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rdy) begin
                    case (mem_data)
                        2'b01: begin
                            rej_d   = 1'b1;
                            state_d = S_PLAY;
                        end
                        2'b10: begin
                            pos_x_d = tgt_x_q;
                            pos_y_d = tgt_y_q;
                            ok_d    = 1'b1;
                            state_d = S_WON;
                        end
                        default: begin
                            pos_x_d = tgt_x_q;
                            pos_y_d = tgt_y_q;
                            ok_d    = 1'b1;
                            state_d = S_PLAY;
                        end
                    endcase
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WON:   state_d = S_WON;
            S_LOST:  state_d = S_LOST;
            default: state_d = S_IDLE;
        endcase
        // A goal reached on the timeout cycle still counts as a win.
        if (timeout_s && (state_d != S_WON)) begin
            state_d = S_LOST;
        end else begin
            state_d = state_d;
        end
        if (restart) begin
            state_d = S_PLAY;
            pos_x_d = START_XP;
            pos_y_d = START_YP;
            ok_d    = 1'b0;
            rej_d   = 1'b0;
        end else begin
            state_d = state_d;
        end
        mem_rd_d  = (state_d == S_FETCH);
        busy_d    = (state_d == S_FETCH) || (state_d == S_WAIT);
        playing_d = (state_d == S_PLAY) || busy_d;
        won_d     = (state_d == S_WON);
        lost_d    = (state_d == S_LOST);
    end

`ifdef MAZE_MOVE_COUNT_EN
    // Saturating count of accepted moves in the current game.
    always_comb begin
        mcnt_d = mcnt_q;
        if (restart) begin
            mcnt_d = 8'd0;
        end else if (ok_d && (mcnt_q != 8'd255)) begin
            mcnt_d = mcnt_q + 8'd1;
        end else begin
            mcnt_d = mcnt_q;
        end
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge nst) begin
        if (!nst) begin
            state_q    <= S_IDLE;
            pos_x_q    <= START_XP;
            pos_y_q    <= START_YP;
            tgt_x_q    <= START_XP;
            tgt_y_q    <= START_YP;
            time_q     <= TIME_Z;
            cnt_q      <= {CNT_W{1'b0}};
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
            rej_q      <= 1'b0;
            playing_q  <= 1'b0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
`ifdef MAZE_MOVE_COUNT_EN
            mcnt_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            time_q     <= time_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= busy_d;
            ok_q       <= ok_d;
            rej_q      <= rej_d;
            playing_q  <= playing_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
`ifdef MAZE_MOVE_COUNT_EN
            mcnt_q     <= mcnt_d;
`endif
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign time_left = time_q;
    assign busy      = busy_q;
    assign move_ok   = ok_q;
    assign move_rej  = rej_q;
    assign playing   = playing_q;
    assign won       = won_q;
    assign lost      = lost_q;
`ifdef MAZE_MOVE_COUNT_EN
    assign move_cnt  = mcnt_q;
`endif

endmodule

// File: tb/tb_maze_core.sv
// Directed bench for maze_core: cycle vector table plus timer, win and restart sequences.
module tb_maze_core;

    logic       clk = 1'b0;
    logic       nst;
    logic       restart, move_valid, mem_rdy, mem_rd;
    logic [1:0] move_dir, mem_data;
    logic [5:0] mem_addr;
    logic [2:0] pos_x, pos_y;
    logic [7:0] time_left;
    logic       busy, move_ok, move_rej, playing, won, lost;
`ifdef MAZE_MOVE_COUNT_EN
    logic [7:0] move_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maze_core #(.TICK_DIV(4), .TIME_INIT(3)) dut (
        .clk(clk), .nst(nst), .restart(restart), .move_valid(move_valid),
        .move_dir(move_dir), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_rdy(mem_rdy), .pos_x(pos_x), .pos_y(pos_y),
        .time_left(time_left), .busy(busy), .move_ok(move_ok),
        .move_rej(move_rej), .playing(playing), .won(won), .lost(lost)
`ifdef MAZE_MOVE_COUNT_EN
        , .move_cnt(move_cnt)
`endif
    );

`ifdef MAZE_MOVE_COUNT_EN
    logic       b_restart, b_mv, b_rdy, b_rd, b_busy, b_ok, b_rej, b_play, b_won, b_lost;
    logic [1:0] b_dir;
    logic [5:0] b_addr;
    logic [2:0] b_px, b_py;
    logic [7:0] b_tl, b_cnt;

    maze_core #(.TICK_DIV(1000), .TIME_INIT(200)) dut_cnt (
        .clk(clk), .nst(nst), .restart(b_restart), .move_valid(b_mv),
        .move_dir(b_dir), .mem_rd(b_rd), .mem_addr(b_addr),
        .mem_data(2'b00), .mem_rdy(b_rdy), .pos_x(b_px), .pos_y(b_py),
        .time_left(b_tl), .busy(b_busy), .move_ok(b_ok),
        .move_rej(b_rej), .playing(b_play), .won(b_won), .lost(b_lost),
        .move_cnt(b_cnt)
    );
`endif

    typedef struct {
        logic       rs, mv, rdy;
        logic [1:0] dir, dat;
        logic [2:0] px, py;
        logic [7:0] tl;
        logic       busy, ok, rej, rd;
        logic [5:0] addr;
        logic       play, won, lost;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input int rs, mv, dir, rdy, dat, px, py, tl,
                                input int busy_e, ok, rej, rd, addr, play, won_e, lost_e);
        vec_t v;
        v.rs = rs[0];  v.mv = mv[0];  v.dir = dir[1:0];  v.rdy = rdy[0];  v.dat = dat[1:0];
        v.px = px[2:0]; v.py = py[2:0]; v.tl = tl[7:0];
        v.busy = busy_e[0]; v.ok = ok[0]; v.rej = rej[0]; v.rd = rd[0]; v.addr = addr[5:0];
        v.play = play[0]; v.won = won_e[0]; v.lost = lost_e[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        restart = 1'b0; move_valid = 1'b0; move_dir = 2'd0; mem_rdy = 1'b0; mem_data = 2'd0;
    endtask

    initial begin
        nst = 1'b0;
        idle_inputs();
`ifdef MAZE_MOVE_COUNT_EN
        b_restart = 1'b0; b_mv = 1'b0; b_dir = 2'd0; b_rdy = 1'b0;
`endif
        // cycle table: rs mv dir rdy dat | px py tl | busy ok rej rd addr | play won lost
        vecs[0]  = mk(1,0,0,0,0, 0,0,3, 0,0,0,0,0, 1,0,0);
        vecs[1]  = mk(0,1,3,0,0, 0,0,3, 1,0,0,1,1, 1,0,0);
        vecs[2]  = mk(0,0,0,0,0, 0,0,3, 1,0,0,0,0, 1,0,0);
        vecs[3]  = mk(0,0,0,1,0, 1,0,3, 0,1,0,0,0, 1,0,0);
        vecs[4]  = mk(0,0,0,0,0, 1,0,2, 0,0,0,0,0, 1,0,0);
        vecs[5]  = mk(1,0,0,0,0, 0,0,3, 0,0,0,0,0, 1,0,0);
        vecs[6]  = mk(0,1,0,0,0, 0,0,3, 0,0,1,0,0, 1,0,0);
        vecs[7]  = mk(0,1,2,0,0, 0,0,3, 0,0,1,0,0, 1,0,0);
        vecs[8]  = mk(0,0,0,0,0, 0,0,3, 0,0,0,0,0, 1,0,0);
        vecs[9]  = mk(1,0,0,0,0, 0,0,3, 0,0,0,0,0, 1,0,0);
        vecs[10] = mk(0,1,3,0,0, 0,0,3, 1,0,0,1,1, 1,0,0);
        vecs[11] = mk(0,1,1,0,0, 0,0,3, 1,0,0,0,0, 1,0,0);
        vecs[12] = mk(0,0,0,0,0, 0,0,3, 1,0,0,0,0, 1,0,0);
        vecs[13] = mk(0,1,3,0,0, 0,0,2, 1,0,0,0,0, 1,0,0);
        vecs[14] = mk(0,0,0,1,1, 0,0,2, 0,0,1,0,0, 1,0,0);
        vecs[15] = mk(0,0,0,0,0, 0,0,2, 0,0,0,0,0, 1,0,0);
        vecs[16] = mk(0,1,1,0,0, 0,0,2, 1,0,0,1,8, 1,0,0);
        vecs[17] = mk(0,0,0,0,0, 0,0,1, 1,0,0,0,0, 1,0,0);
        vecs[18] = mk(0,0,0,1,3, 0,1,1, 0,1,0,0,0, 1,0,0);
        vecs[19] = mk(0,0,0,0,0, 0,1,1, 0,0,0,0,0, 1,0,0);

        tick();
        tick();
        chk("reset pos", 32'({pos_x, pos_y}), 32'h0);
        chk("reset time", 32'(time_left), 32'd0);
        chk("reset flags", 32'({busy, move_ok, move_rej, mem_rd, playing, won, lost}), 32'h0);
        chk("reset addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        nst = 1'b1;
        #1;

        for (int i = 0; i < 20; i++) begin
            restart = vecs[i].rs; move_valid = vecs[i].mv; move_dir = vecs[i].dir;
            mem_rdy = vecs[i].rdy; mem_data = vecs[i].dat;
            tick();
            chk($sformatf("vec%0d pos", i), 32'({pos_x, pos_y}), 32'({vecs[i].px, vecs[i].py}));
            chk($sformatf("vec%0d time", i), 32'(time_left), 32'(vecs[i].tl));
            chk($sformatf("vec%0d flags", i),
                32'({busy, move_ok, move_rej, mem_rd, playing, won, lost}),
                32'({vecs[i].busy, vecs[i].ok, vecs[i].rej, vecs[i].rd,
                     vecs[i].play, vecs[i].won, vecs[i].lost}));
            if (vecs[i].rd) chk($sformatf("vec%0d addr", i), 32'(mem_addr), 32'(vecs[i].addr));
        end
        idle_inputs();

        // timeout with no moves, then moves ignored
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t4 load", 32'(time_left), 32'd3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4)  chk("t4 tl@4", 32'(time_left), 32'd2);
            if (k == 8)  chk("t4 tl@8", 32'(time_left), 32'd1);
            if (k == 11) chk("t4 live@11", 32'({time_left, playing, lost}), 32'({8'd1, 1'b1, 1'b0}));
            if (k == 12) chk("t4 lost@12", 32'({time_left, playing, won, lost}), 32'({8'd0, 3'b001}));
        end
        move_valid = 1'b1; move_dir = 2'd3;
        tick();
        move_valid = 1'b0;
        chk("t4 move ignored", 32'({busy, mem_rd, move_ok, move_rej}), 32'h0);
        repeat (5) tick();
        chk("t4 frozen", 32'({time_left, pos_x, pos_y, lost}), 32'({8'd0, 3'd0, 3'd0, 1'b1}));

        // goal resolves on the same edge the timer would expire
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (8) tick();
        move_valid = 1'b1; move_dir = 2'd3;
        tick();
        move_valid = 1'b0;
        chk("t5 fetch", 32'({busy, mem_rd, mem_addr}), 32'({1'b1, 1'b1, 6'd1}));
        tick();
        tick();
        chk("t5 wait", 32'({busy, time_left}), 32'({1'b1, 8'd1}));
        mem_rdy = 1'b1; mem_data = 2'b10;
        tick();
        mem_rdy = 1'b0; mem_data = 2'b00;
        chk("t5 won", 32'({won, lost, playing, move_ok, pos_x, pos_y}),
            32'({1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0}));
        move_valid = 1'b1; move_dir = 2'd2;
        tick();
        move_valid = 1'b0;
        repeat (5) tick();
        chk("t5 hold", 32'({won, lost, busy, move_ok, pos_x, pos_y}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0}));
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5 restart", 32'({playing, won, lost, time_left, pos_x, pos_y}),
            32'({3'b100, 8'd3, 3'd0, 3'd0}));

        // restart during WAIT discards the pending read
        move_valid = 1'b1; move_dir = 2'd3;
        tick();
        move_valid = 1'b0;
        tick();
        chk("t6 in wait", 32'({busy, mem_rd}), 32'({1'b1, 1'b0}));
        restart = 1'b1;
        tick();
        restart = 1'b0; mem_rdy = 1'b1; mem_data = 2'b00;
        tick();
        mem_rdy = 1'b0;
        chk("t6 discarded", 32'({move_ok, busy, playing, pos_x, pos_y}),
            32'({1'b0, 1'b0, 1'b1, 3'd0, 3'd0}));
        tick();
        chk("t6 no late ok", 32'({move_ok, pos_x}), 32'({1'b0, 3'd0}));

`ifdef MAZE_MOVE_COUNT_EN
        b_restart = 1'b1;
        tick();
        b_restart = 1'b0;
        chk("cnt cleared", 32'(b_cnt), 32'd0);
        for (int i = 0; i < 256; i++) begin
            b_mv = 1'b1; b_dir = (i % 2 == 0) ? 2'd3 : 2'd2;
            tick();
            b_mv = 1'b0;
            tick();
            b_rdy = 1'b1;
            tick();
            b_rdy = 1'b0;
            if (i == 0)   chk("cnt first", 32'(b_cnt), 32'd1);
            if (i == 254) chk("cnt 255", 32'(b_cnt), 32'd255);
        end
        chk("cnt saturated", 32'(b_cnt), 32'd255);
        b_restart = 1'b1;
        tick();
        b_restart = 1'b0;
        chk("cnt restart", 32'(b_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
